// File: rtl/decoder416_pkg.sv
// Shared widths and the FSM state type for the sequenced 4-to-16 decoder.
package decoder416_pkg;

    localparam int CODE_W   = 4;
    localparam int ONEHOT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        SWEEP = 2'd2
    } state_t;

endpackage

// File: rtl/decoder416_seq_if.sv
// Request side (valid/ready + code) and beat side (valid/ready + one-hot) of the decoder.
interface decoder416_seq_if;
    import decoder416_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [CODE_W-1:0]   in_code;
    logic                in_sweep;
    logic                out_valid;
    logic                out_ready;
    logic [ONEHOT_W-1:0] out_onehot;
    logic                out_last;

    modport master (
        output in_valid, in_code, in_sweep, out_ready,
        input  in_ready, out_valid, out_onehot, out_last
    );

    modport slave (
        input  in_valid, in_code, in_sweep, out_ready,
        output in_ready, out_valid, out_onehot, out_last
    );

endinterface

// File: rtl/dec4to16.sv
// Purely combinational binary-to-one-hot decode.
module dec4to16
    import decoder416_pkg::*;
(
    input  logic [CODE_W-1:0]   code,
    output logic [ONEHOT_W-1:0] onehot
);

    assign onehot = ONEHOT_W'(1) << code;

endmodule

// File: rtl/decoder416_seq.sv
// Accepts a 4-bit code and emits either one one-hot beat or an ascending sweep 0..code,
// with valid/ready backpressure on the output and a synchronous flush.
module decoder416_seq
    import decoder416_pkg::*;
#(
    parameter bit ZERO_WHEN_IDLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    output logic             busy,
    decoder416_seq_if.slave  bus
);

    state_t              state;
    logic [CODE_W-1:0]   idx;
    logic [CODE_W-1:0]   limit;
    logic                out_valid;
    logic                out_last;
    logic                has_beat;
    logic [ONEHOT_W-1:0] dec_onehot;

    logic accept;
    logic beat_done;

    assign accept    = bus.in_valid && bus.in_ready;
    assign beat_done = out_valid && bus.out_ready;

    dec4to16 u_dec (
        .code   (idx),
        .onehot (dec_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            limit     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            has_beat  <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        has_beat  <= 1'b1;
                        limit     <= bus.in_code;
                        if (bus.in_sweep) begin
                            state    <= SWEEP;
                            idx      <= '0;
                            out_last <= (bus.in_code == '0);
                        end else begin
                            state    <= EMIT;
                            idx      <= bus.in_code;
                            out_last <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (beat_done) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (beat_done) begin
                        // idx only advances while below limit, so it never wraps past 15
                        if (idx == limit) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            idx      <= idx + CODE_W'(1);
                            out_last <= ((idx + CODE_W'(1)) == limit);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !flush;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;

    // has_beat keeps the reset value all-zero even when the last beat is held while idle
    assign bus.out_onehot = (out_valid || (!ZERO_WHEN_IDLE && has_beat)) ? dec_onehot
                                                                         : '0;

endmodule

// File: tb/tb_decoder416_seq.sv
// Directed, table-driven checks of the sequenced 4-to-16 decoder.
module tb_decoder416_seq;

    logic clk;
    logic rst_n;
    logic flush;
    logic busy;

    decoder416_seq_if bus ();

    decoder416_seq #(.ZERO_WHEN_IDLE(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [3:0]  code;
        logic        sw;
        logic        fl;
        logic        ordy;
        logic        irdy;
        logic        ov;
        logic [15:0] oh;
        logic        last;
        logic        bsy;
    } vec_t;

    vec_t tbl[$];
    int   vectors;
    int   miscompares;

    function automatic vec_t mk(logic iv, logic [3:0] code, logic sw, logic fl, logic ordy,
                                logic irdy, logic ov, logic [15:0] oh, logic last, logic bsy);
        vec_t v;
        v.iv = iv; v.code = code; v.sw = sw; v.fl = fl; v.ordy = ordy;
        v.irdy = irdy; v.ov = ov; v.oh = oh; v.last = last; v.bsy = bsy;
        return v;
    endfunction

    task automatic drive(logic iv, logic [3:0] code, logic sw, logic fl, logic ordy);
        bus.in_valid  = iv;
        bus.in_code   = code;
        bus.in_sweep  = sw;
        flush         = fl;
        bus.out_ready = ordy;
    endtask

    task automatic check(string name, logic irdy, logic ov, logic [15:0] oh, logic last,
                         logic bsy);
        vectors++;
        if (bus.in_ready !== irdy || bus.out_valid !== ov || bus.out_onehot !== oh ||
            bus.out_last !== last || busy !== bsy) begin
            miscompares++;
            $display("FAIL %s: got rdy=%b vld=%b oh=%h last=%b busy=%b, want rdy=%b vld=%b oh=%h last=%b busy=%b",
                     name, bus.in_ready, bus.out_valid, bus.out_onehot, bus.out_last, busy,
                     irdy, ov, oh, last, bsy);
        end
    endtask

    // One cycle: drive just after the rising edge, observe on the falling edge.
    task automatic step(string name, logic iv, logic [3:0] code, logic sw, logic fl,
                        logic ordy, logic irdy, logic ov, logic [15:0] oh, logic last,
                        logic bsy);
        @(posedge clk);
        #1;
        drive(iv, code, sw, fl, ordy);
        @(negedge clk);
        check(name, irdy, ov, oh, last, bsy);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Columns: iv code sw fl ordy | in_ready out_valid onehot last busy
        // single code 5, plus a request offered during the final handshake (ignored)
        tbl.push_back(mk(0, 4'd0, 0, 0, 0,  1, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 4'd5, 0, 0, 1,  1, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 4'd7, 0, 0, 1,  0, 1, 16'h0020, 1, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 1,  1, 0, 16'h0000, 0, 0));
        // sweep to 3
        tbl.push_back(mk(1, 4'd3, 1, 0, 1,  1, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 1,  0, 1, 16'h0001, 0, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 1,  0, 1, 16'h0002, 0, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 1,  0, 1, 16'h0004, 0, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 1,  0, 1, 16'h0008, 1, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 1,  1, 0, 16'h0000, 0, 0));
        // sweep to 2, beat 0002 stalled three cycles
        tbl.push_back(mk(1, 4'd2, 1, 0, 1,  1, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 1,  0, 1, 16'h0001, 0, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0,  0, 1, 16'h0002, 0, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0,  0, 1, 16'h0002, 0, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0,  0, 1, 16'h0002, 0, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 1,  0, 1, 16'h0002, 0, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 1,  0, 1, 16'h0004, 1, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 1,  1, 0, 16'h0000, 0, 0));
        // sweep to 0 yields a single last beat
        tbl.push_back(mk(1, 4'd0, 1, 0, 1,  1, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 1,  0, 1, 16'h0001, 1, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 1,  1, 0, 16'h0000, 0, 0));
        // single code 14 stalled: busy and beat held
        tbl.push_back(mk(1, 4'd14, 0, 0, 0, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 0,  0, 1, 16'h4000, 1, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 1,  0, 1, 16'h4000, 1, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 1,  1, 0, 16'h0000, 0, 0));
        // flush on third beat of sweep to 10
        tbl.push_back(mk(1, 4'd10, 1, 0, 1, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 1,  0, 1, 16'h0001, 0, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 1,  0, 1, 16'h0002, 0, 1));
        tbl.push_back(mk(0, 4'd0, 0, 1, 1,  0, 1, 16'h0004, 0, 1));
        tbl.push_back(mk(0, 4'd0, 0, 0, 1,  1, 0, 16'h0000, 0, 0));
        // flush together with a request in IDLE: not accepted
        tbl.push_back(mk(1, 4'd6, 0, 1, 1,  0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 4'd0, 0, 0, 1,  1, 0, 16'h0000, 0, 0));

        @(negedge clk);
        check("reset", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i])
            step($sformatf("vec%0d", i), tbl[i].iv, tbl[i].code, tbl[i].sw, tbl[i].fl,
                 tbl[i].ordy, tbl[i].irdy, tbl[i].ov, tbl[i].oh, tbl[i].last, tbl[i].bsy);

        // Full sweep to 15: 16 beats, no wrap, then idle
        step("sw15_acc", 1'b1, 4'd15, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++)
            step($sformatf("sw15_beat%0d", k), 1'b0, 4'd0, 1'b0, 1'b0, 1'b1,
                 1'b0, 1'b1, 16'h0001 << k, (k == 15), 1'b1);
        step("sw15_idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Reset asserted between edges in the middle of a sweep
        step("rst_acc", 1'b1, 4'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        step("rst_b0", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1);
        step("rst_b1", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        step("post_acc", 1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        step("post_beat", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0200, 1'b1, 1'b1);
        step("post_idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decoder416_seq.md
DECODER416_SEQ -- requirements
Module: decoder416_seq

Interface
REQ-001 Parameter ZERO_WHEN_IDLE, default 1, meaning: 1 = out_onehot forced to 16'h0000 whenever out_valid=0; 0 = out_onehot holds the last beat.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  request present on in_code/in_sweep.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 in_code  input  4  binary index 0..15.
REQ-007 in_sweep  input  1  0 = single one-hot beat; 1 = ascending sweep of beats 0..in_code.
REQ-008 flush  input  1  synchronous abort of any pending or in-progress output.
REQ-009 out_valid  output  1  out_onehot/out_last valid.
REQ-010 out_ready  input  1  consumer accepts the current beat.
REQ-011 out_onehot  output  16  bit k set for index k, all other bits 0.
REQ-012 out_last  output  1  final beat of the current request.
REQ-013 busy  output  1  state is not IDLE.

Function
REQ-014 States SHALL be IDLE, EMIT and SWEEP.
REQ-015 in_ready SHALL be 1 only when state=IDLE and flush=0.
REQ-016 Accept occurs when in_valid & in_ready: in_code latched to cur, in_sweep=0 -> EMIT with idx=cur; in_sweep=1 -> SWEEP with idx=0, limit=cur.
REQ-017 Latency: out_valid SHALL rise on the clock edge that accepts the request, i.e. the first beat is visible the cycle after acceptance.
REQ-018 out_onehot SHALL equal 16'h0001 << idx while out_valid=1; exactly one bit is ever set.
REQ-019 While out_valid=1 & out_ready=0, out_onehot, out_last and state SHALL hold stable.
REQ-020 EMIT: out_last=1; on out_ready -> IDLE, out_valid falls next edge.
REQ-021 SWEEP: out_last = (idx==limit); on out_ready with idx<limit, idx increments by 1 and out_valid stays 1, giving back-to-back beats; on out_ready with idx==limit -> IDLE.
REQ-022 Sweep with limit=0 SHALL produce exactly one beat (16'h0001, out_last=1).
REQ-023 Sweep with limit=15 SHALL produce 16 beats ending at 16'h8000; idx SHALL NOT wrap.
REQ-024 A new request SHALL NOT be accepted in the cycle that the last beat handshakes; in_ready returns the following cycle (one idle bubble minimum).
REQ-025 flush=1 in any state SHALL force IDLE and out_valid=0 on the next edge; a beat handshaking in the same cycle counts as delivered; flush has priority over accept.
REQ-026 busy SHALL be 1 in EMIT and SWEEP, including while stalled.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=IDLE, out_valid=0, out_last=0, busy=0, idx=0, limit=0, out_onehot=16'h0000 regardless of parameter.
REQ-028 Reset asserted mid-sweep SHALL discard the sweep; after release the first cycle has in_ready=1 with no residual beat.

Structure
REQ-029 Package decoder416_pkg SHALL hold CODE_W=4, ONEHOT_W=16 and the state enum type.
REQ-030 Combinational 4-to-16 decode SHALL be a sub-module dec4to16, instantiated once on idx; the FSM, handshake and counters live in decoder416_seq.

Verification
REQ-031 Single: in_code=4'd5, in_sweep=0, out_ready=1 -> one beat 16'h0020, out_last=1, then in_ready=1 one cycle later.
REQ-032 Sweep: in_code=4'd3, in_sweep=1, out_ready=1 -> beats 0001,0002,0004,0008 on consecutive cycles, out_last only on 0008.
REQ-033 Backpressure: sweep to 2 with out_ready low 3 cycles on beat 0002 -> 0002 held 4 cycles, no beat lost or repeated.
REQ-034 Boundaries: sweep in_code=0 -> single 0001 with last; sweep in_code=15 -> 16 beats ending 8000, then IDLE.
REQ-035 Flush: flush during the third beat of sweep to 10 -> out_valid=0 next cycle, busy=0, in_ready=1; flush with in_valid simultaneous in IDLE -> request not accepted.
REQ-036 Reset: rst_n low mid-sweep between edges -> outputs zero immediately; after release, a new single request for 4'd9 yields 16'h0200.
